// File: rtl/xcvr_init_pkg.sv
// Shared types and constants for the transceiver lane reset sequencer.
//   lane_state_e : sequencer state, fixed 3-bit encodings (visible on STATE)
//   RETRY_W      : width of the saturating timeout counter
package xcvr_init_pkg;

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    StWaitPll   = 3'd0,
    StPllStable = 3'd1,
    StPmaRst    = 3'd2,
    StPmaWait   = 3'd3,
    StPcsRst    = 3'd4,
    StWaitRx    = 3'd5,
    StReady     = 3'd6,
    StFail      = 3'd7
  } lane_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop bit synchronizer for an asynchronous level input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both stages clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i edges of latency
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/xcvr_lane_init.sv
// Reset sequencer for one transceiver lane fed by the TX PLL.
// Qualifies PLL lock, pulses the PMA reset, waits for the TX clock, holds and
// releases the PCS reset, then waits for CDR lock before reporting LINK_READY.
// Timeouts in PMA_WAIT / WAIT_RX trigger a retry from WAIT_PLL until the retry
// budget is spent, after which the block parks in FAIL.
//   CLK            : free-running fabric clock
//   RESET_N        : asynchronous active-low reset
//   PLL_LOCK       : TX PLL lock (async)
//   TX_CLK_STABLE  : lane TX clock stable (async)
//   RX_READY       : lane CDR lock (async)
//   FORCE_RESET    : synchronous single-cycle restart, clears ERROR/RETRY_CNT
//   LANE_PMA_RST_N : lane PMA reset, active-low
//   LANE_PCS_RST_N : lane PCS reset, active-low
//   LINK_READY     : lane is up
//   ERROR          : sticky, retry budget exhausted
//   RETRY_CNT      : timeouts seen, saturating
//   STATE          : current state encoding
module xcvr_lane_init
  import xcvr_init_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned PMA_RST_CYCLES     = 64,
  parameter int unsigned PCS_WAIT_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES     = 65536,
  parameter int unsigned MAX_RETRY          = 7,
  parameter int unsigned CNT_W              = 17
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               PLL_LOCK,
  input  logic               TX_CLK_STABLE,
  input  logic               RX_READY,
  input  logic               FORCE_RESET,
  output logic               LANE_PMA_RST_N,
  output logic               LANE_PCS_RST_N,
  output logic               LINK_READY,
  output logic               ERROR,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [2:0]         STATE
);

  // Counter is 0 on the first cycle in a state, so an N-cycle state ends at N-1.
  localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PmaLast  = CNT_W'(PMA_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PcsLast  = CNT_W'(PCS_WAIT_CYCLES - 1);
  // Timeout fires on the cycle the counter reaches the limit itself.
  localparam logic [CNT_W-1:0] TimeoutHit = CNT_W'(TIMEOUT_CYCLES);

  logic lock_s, txs_s, rxr_s;

  sync2 u_sync_lock (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (PLL_LOCK),
    .q_o    (lock_s)
  );

  sync2 u_sync_txs (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (TX_CLK_STABLE),
    .q_o    (txs_s)
  );

  sync2 u_sync_rxr (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (RX_READY),
    .q_o    (rxr_s)
  );

  lane_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               error_q, error_d;
  logic               pma_rst_n_q, pma_rst_n_d;
  logic               pcs_rst_n_q, pcs_rst_n_d;
  logic               link_ready_q, link_ready_d;
  logic               timeout;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    error_d = error_q;
    timeout = ((state_q == StPmaWait) || (state_q == StWaitRx)) && (cnt_q == TimeoutHit);

    if (FORCE_RESET) begin
      state_d = StWaitPll;
      retry_d = '0;
      error_d = 1'b0;
    end else if (!lock_s && (state_q != StWaitPll) && (state_q != StFail)) begin
      state_d = StWaitPll;
    end else if (timeout) begin
      retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
      // Budget check uses the count before this timeout is added.
      if (int'(retry_q) >= int'(MAX_RETRY)) begin
        state_d = StFail;
        error_d = 1'b1;
      end else begin
        state_d = StWaitPll;
      end
    end else begin
      case (state_q)
        StWaitPll:   if (lock_s) state_d = StPllStable;
        StPllStable: if (cnt_q == LockLast) state_d = StPmaRst;
        StPmaRst:    if (cnt_q == PmaLast) state_d = StPmaWait;
        StPmaWait:   if (txs_s) state_d = StPcsRst;
        StPcsRst:    if (cnt_q == PcsLast) state_d = StWaitRx;
        StWaitRx:    if (rxr_s) state_d = StReady;
        StReady: begin
          // TX clock loss needs a full restart; CDR loss only re-inits the PCS.
          if (!txs_s) begin
            state_d = StWaitPll;
          end else if (!rxr_s) begin
            state_d = StPcsRst;
          end
        end
        StFail:      state_d = StFail;
        default:     state_d = StWaitPll;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs decoded from the next state so they move with STATE.
    pma_rst_n_d  = 1'b0;
    pcs_rst_n_d  = 1'b0;
    link_ready_d = 1'b0;
    case (state_d)
      StPmaWait, StPcsRst: pma_rst_n_d = 1'b1;
      StWaitRx: begin
        pma_rst_n_d = 1'b1;
        pcs_rst_n_d = 1'b1;
      end
      StReady: begin
        pma_rst_n_d  = 1'b1;
        pcs_rst_n_d  = 1'b1;
        link_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StWaitPll;
      cnt_q        <= '0;
      retry_q      <= '0;
      error_q      <= 1'b0;
      pma_rst_n_q  <= 1'b0;
      pcs_rst_n_q  <= 1'b0;
      link_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      error_q      <= error_d;
      pma_rst_n_q  <= pma_rst_n_d;
      pcs_rst_n_q  <= pcs_rst_n_d;
      link_ready_q <= link_ready_d;
    end
  end

  assign LANE_PMA_RST_N = pma_rst_n_q;
  assign LANE_PCS_RST_N = pcs_rst_n_q;
  assign LINK_READY     = link_ready_q;
  assign ERROR          = error_q;
  assign RETRY_CNT      = retry_q;
  assign STATE          = state_q;

endmodule
